// File: rtl/median_pkg.sv
// Shared definitions for the median-filter datapath.
// Contents:
//   PIX_W    - default pixel width in bits
//   col_lo   - low bit index of slice k in a packed pixel column
//   bank_mod - non-negative modulo used for circular line-bank selection
package median_pkg;

  localparam int unsigned PIX_W = 8;

  // Low bit of column slice k when each slice is w bits wide
  function automatic int unsigned col_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

  // Modulo that stays non-negative for negative v (bank - k wraps around)
  function automatic int unsigned bank_mod(input int v, input int unsigned n);
    int m;
    m = v % int'(n);
    if (m < 0) m = m + int'(n);
    return unsigned'(m);
  endfunction

endpackage

// File: rtl/line_window_buffer_bram.sv
// Simple dual-port block RAM, one line of pixels.
// Ports:
//   clk, rst  - clock; rst clears only the read-data register, not the array
//   i_a_we    - port A write enable
//   i_a_addr  - port A write address
//   i_a_din   - port A write data
//   i_b_re    - port B read enable
//   i_b_addr  - port B read address
//   o_b_dout  - port B registered read data (read-first on address collision)
module line_window_buffer_bram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_din,
  input  logic              i_b_re,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [DATA_W-1:0] o_b_dout
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;

  // Write port
  always_ff @(posedge clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_din;
  end

  // Read port; non-blocking update of r_mem makes same-address reads return old data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout <= '0;
    end else if (i_b_re) begin
      r_dout <= r_mem[i_b_addr];
    end
  end

  assign o_b_dout = r_dout;

endmodule

// File: rtl/line_window_buffer.sv
// Multi-line video buffer: stores the last LINES lines in circular banks and
// emits, for each incoming pixel, the column of LINES+1 pixels at that x.
// Ports:
//   clk, rst            - pixel clock, async active-high reset
//   vsync, hsync        - frame start / line end strobes
//   din, din_valid      - incoming pixel and qualifier
//   col_out             - column; slice 0 = current pixel, slice k = k lines above
//   col_x, col_valid    - x position and qualifier of col_out (1-cycle latency)
//   width               - pixel count of the last completed line
//   rows_ready          - LINES non-empty lines stored since vsync
//   overflow            - pixel arrived after the last line address was written
module line_window_buffer
  import median_pkg::*;
#(
  parameter int unsigned DATA_W = PIX_W,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LINES  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vsync,
  input  logic                        hsync,
  input  logic [DATA_W-1:0]           din,
  input  logic                        din_valid,
  output logic [(LINES+1)*DATA_W-1:0] col_out,
  output logic [ADDR_W-1:0]           col_x,
  output logic                        col_valid,
  output logic [ADDR_W-1:0]           width,
  output logic                        rows_ready,
  output logic                        overflow
);

  localparam int unsigned BANK_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned FILL_W = $clog2(LINES + 1);
  localparam int unsigned CNT_W  = ADDR_W + 1;
  localparam int unsigned COL_W  = (LINES + 1) * DATA_W;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_last_done;
  logic [BANK_W-1:0] r_wr_bank;
  logic [FILL_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_px_in_line;
  logic [ADDR_W-1:0] r_width;
  logic              r_overflow;
  logic              r_rows_ready;
  logic [DATA_W-1:0] r_din;
  logic [BANK_W-1:0] r_rd_bank;
  logic [ADDR_W-1:0] r_col_x;
  logic              r_col_valid;

  logic [ADDR_W-1:0] w_wr_addr;
  logic [BANK_W-1:0] w_wr_bank;
  logic              w_drop;
  logic              w_we;
  logic [CNT_W-1:0]  w_px_cnt;
  logic              w_line_end;
  logic [BANK_W-1:0] w_bank_next;
  logic              w_fill_full;
  logic [ADDR_W-1:0] w_width_sat;
  logic [DATA_W-1:0] w_rd [LINES];
  logic [COL_W-1:0]  w_col;

  // vsync restarts addressing in the same cycle so a coincident pixel lands at bank 0, x 0
  assign w_wr_addr   = vsync ? '0 : r_wr_addr;
  assign w_wr_bank   = vsync ? '0 : r_wr_bank;
  assign w_drop      = din_valid && !vsync && r_last_done;
  assign w_we        = din_valid && !w_drop;
  assign w_px_cnt    = (vsync ? '0 : r_px_in_line) + CNT_W'(w_we);
  assign w_line_end  = hsync && !vsync && (w_px_cnt != '0);
  assign w_bank_next = BANK_W'(bank_mod(int'(r_wr_bank) + 1, LINES));
  assign w_fill_full = (r_fill == FILL_W'(LINES));
  // A completely filled line (2**ADDR_W pixels) does not fit in width; report the maximum
  assign w_width_sat = w_px_cnt[ADDR_W] ? ADDR_MAX : w_px_cnt[ADDR_W-1:0];

  // Line banks: all read at the write address, only the current bank written
  for (genvar b = 0; b < LINES; b++) begin : g_bank
    line_window_buffer_bram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_bram (
      .clk      (clk),
      .rst      (rst),
      .i_a_we   (w_we && (w_wr_bank == BANK_W'(b))),
      .i_a_addr (w_wr_addr),
      .i_a_din  (din),
      .i_b_re   (din_valid),
      .i_b_addr (w_wr_addr),
      .o_b_dout (w_rd[b])
    );
  end

  // Line control: address, pixel count, bank rotation, fill level, width, overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr    <= '0;
      r_last_done  <= 1'b0;
      r_wr_bank    <= '0;
      r_fill       <= '0;
      r_px_in_line <= '0;
      r_width      <= '0;
      r_overflow   <= 1'b0;
      r_rows_ready <= 1'b0;
    end else if (vsync) begin
      r_wr_addr    <= w_we ? ADDR_W'(1) : '0;
      r_last_done  <= 1'b0;
      r_wr_bank    <= '0;
      r_fill       <= '0;
      r_px_in_line <= w_px_cnt;
      r_overflow   <= 1'b0;
      r_rows_ready <= 1'b0;
    end else begin
      r_rows_ready <= w_fill_full;
      if (w_drop) r_overflow <= 1'b1;
      if (w_line_end) begin
        r_width      <= w_width_sat;
        r_wr_bank    <= w_bank_next;
        r_wr_addr    <= '0;
        r_last_done  <= 1'b0;
        r_px_in_line <= '0;
        if (!w_fill_full) r_fill <= r_fill + FILL_W'(1);
      end else if (w_we) begin
        r_px_in_line <= w_px_cnt;
        // Saturate: last address stays, further pixels are dropped
        if (r_wr_addr == ADDR_MAX) r_last_done <= 1'b1;
        else                       r_wr_addr   <= r_wr_addr + ADDR_W'(1);
      end
    end
  end

  // Column pipeline aligned with the one-cycle BRAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_din       <= '0;
      r_rd_bank   <= '0;
      r_col_x     <= '0;
      r_col_valid <= 1'b0;
    end else begin
      r_col_valid <= din_valid && r_rows_ready && !vsync;
      if (din_valid) begin
        r_din     <= din;
        r_rd_bank <= w_wr_bank;
        r_col_x   <= w_wr_addr;
      end
    end
  end

  // Slice k comes from the bank k lines behind the one being written at read time
  always_comb begin
    w_col = '0;
    w_col[DATA_W-1:0] = r_din;
    for (int k = 1; k <= int'(LINES); k++) begin
      w_col[col_lo(unsigned'(k), DATA_W) +: DATA_W] =
        w_rd[BANK_W'(bank_mod(int'(r_rd_bank) - k, LINES))];
    end
  end

  assign col_out    = w_col;
  assign col_x      = r_col_x;
  assign col_valid  = r_col_valid;
  assign width      = r_width;
  assign rows_ready = r_rows_ready;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer (DATA_W=2, ADDR_W=3, LINES=2).
module tb_line_window_buffer;

  logic       clk;
  logic       rst;
  logic       vsync;
  logic       hsync;
  logic [1:0] din;
  logic       din_valid;
  logic [5:0] col_out;
  logic [2:0] col_x;
  logic       col_valid;
  logic [2:0] width;
  logic       rows_ready;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;

  line_window_buffer #(
    .DATA_W(2),
    .ADDR_W(3),
    .LINES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vsync     (vsync),
    .hsync     (hsync),
    .din       (din),
    .din_valid (din_valid),
    .col_out   (col_out),
    .col_x     (col_x),
    .col_valid (col_valid),
    .width     (width),
    .rows_ready(rows_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [1:0] d;
    logic       hs;
    logic       vs;
    logic       cv;
    logic [2:0] x;
    logic [5:0] col;
    logic       chk_col;
    logic [2:0] w;
    logic       rr;
    logic       ov;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic dv, input logic [1:0] d, input logic hs, input logic vs,
                     input logic cv, input logic [2:0] x, input logic [5:0] col,
                     input logic chk_col, input logic [2:0] w, input logic rr, input logic ov);
    vec_t v;
    v.dv = dv; v.d = d; v.hs = hs; v.vs = vs; v.cv = cv; v.x = x;
    v.col = col; v.chk_col = chk_col; v.w = w; v.rr = rr; v.ov = ov;
    vq.push_back(v);
  endtask

  // Drive one cycle of inputs, sample just after the edge
  task automatic step(input logic dv, input logic [1:0] d, input logic hs, input logic vs);
    din_valid = dv; din = d; hsync = hs; vsync = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " col_out"},    32'(col_out),    32'd0);
    chk({tag, " col_x"},      32'(col_x),      32'd0);
    chk({tag, " col_valid"},  32'(col_valid),  32'd0);
    chk({tag, " width"},      32'(width),      32'd0);
    chk({tag, " rows_ready"}, 32'(rows_ready), 32'd0);
    chk({tag, " overflow"},   32'(overflow),   32'd0);
  endtask

  initial begin
    logic [1:0] pa [5];
    logic [1:0] pb [5];
    pa[0] = 2; pa[1] = 3; pa[2] = 0; pa[3] = 3; pa[4] = 0;
    pb[0] = 1; pb[1] = 0; pb[2] = 3; pb[3] = 0; pb[4] = 3;

    // Line A (bank 0): nothing valid yet
    for (int i = 0; i < 5; i++) add(1, pa[i], 0, 0, 0, 3'(i), 6'd0, 0, 3'd0, 0, 0);
    add(0, 0, 1, 0, 0, 3'd4, 6'd0, 0, 3'd5, 0, 0);
    // Line B (bank 1)
    for (int i = 0; i < 5; i++) add(1, pb[i], 0, 0, 0, 3'(i), 6'd0, 0, 3'd5, 0, 0);
    add(0, 0, 1, 0, 0, 3'd4, 6'd0, 0, 3'd5, 0, 0);
    add(0, 0, 0, 0, 0, 3'd4, 6'd0, 0, 3'd5, 1, 0);
    // Line C (bank 0): columns {A, B, C}
    add(1, 3, 0, 0, 1, 3'd0, 6'b10_01_11, 1, 3'd5, 1, 0);
    add(1, 3, 0, 0, 1, 3'd1, 6'b11_00_11, 1, 3'd5, 1, 0);
    add(1, 3, 0, 0, 1, 3'd2, 6'b00_11_11, 1, 3'd5, 1, 0);
    add(1, 3, 0, 0, 1, 3'd3, 6'b11_00_11, 1, 3'd5, 1, 0);
    add(1, 3, 0, 0, 1, 3'd4, 6'b00_11_11, 1, 3'd5, 1, 0);
    add(0, 0, 1, 0, 0, 3'd4, 6'd0, 0, 3'd5, 1, 0);
    // Line D (bank 1), hsync with the 4th pixel: columns {B, C, D}
    add(1, 1, 0, 0, 1, 3'd0, 6'b01_11_01, 1, 3'd5, 1, 0);
    add(1, 2, 0, 0, 1, 3'd1, 6'b00_11_10, 1, 3'd5, 1, 0);
    add(1, 3, 0, 0, 1, 3'd2, 6'b11_11_11, 1, 3'd5, 1, 0);
    add(1, 0, 1, 0, 1, 3'd3, 6'b00_11_00, 1, 3'd4, 1, 0);
    // Line E (bank 0), one pixel: {C0, D0, E0}
    add(1, 2, 0, 0, 1, 3'd0, 6'b11_01_10, 1, 3'd4, 1, 0);
    add(0, 0, 1, 0, 0, 3'd0, 6'd0, 0, 3'd1, 1, 0);
    // Empty hsync: ignored
    add(0, 0, 1, 0, 0, 3'd0, 6'd0, 0, 3'd1, 1, 0);
    // Line F (bank 1 if no extra rotation): {D0, E0, F0}
    add(1, 1, 0, 0, 1, 3'd0, 6'b01_10_01, 1, 3'd1, 1, 0);
    for (int i = 1; i < 8; i++) add(1, 2, 0, 0, 1, 3'(i), 6'd0, 0, 3'd1, 1, 0);
    add(1, 2, 0, 0, 1, 3'd7, 6'd0, 0, 3'd1, 1, 1);
    // vsync clears frame state, width holds
    add(0, 0, 0, 1, 0, 3'd7, 6'd0, 0, 3'd1, 0, 0);
    add(1, 3, 0, 0, 0, 3'd0, 6'd0, 0, 3'd1, 0, 0);
    add(1, 3, 0, 0, 0, 3'd1, 6'b00_00_11, 0, 3'd1, 0, 0);

    rst = 1'b1; vsync = 1'b0; hsync = 1'b0; din = '0; din_valid = 1'b0;
    #12;
    chk_all_zero("reset");
    #10;
    rst = 1'b0;

    foreach (vq[i]) begin
      step(vq[i].dv, vq[i].d, vq[i].hs, vq[i].vs);
      chk($sformatf("v%0d col_valid", i),  32'(col_valid),  32'(vq[i].cv));
      chk($sformatf("v%0d col_x", i),      32'(col_x),      32'(vq[i].x));
      chk($sformatf("v%0d width", i),      32'(width),      32'(vq[i].w));
      chk($sformatf("v%0d rows_ready", i), 32'(rows_ready), 32'(vq[i].rr));
      chk($sformatf("v%0d overflow", i),   32'(overflow),   32'(vq[i].ov));
      if (vq[i].chk_col) chk($sformatf("v%0d col_out", i), 32'(col_out), 32'(vq[i].col));
    end

    // Mid-line asynchronous reset between clock edges
    chk("pre-reset col_out slice0", 32'(col_out[1:0]), 32'd3);
    din_valid = 1'b1; din = 2'd3;
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // vsync + hsync + pixel together: vsync only, pixel is x=0 of the frame
    step(1, 3, 1, 1);
    chk("vs+hs width",     32'(width),      32'd0);
    chk("vs+hs col_x",     32'(col_x),      32'd0);
    chk("vs+hs col_valid", 32'(col_valid),  32'd0);
    chk("vs+hs rows_ready",32'(rows_ready), 32'd0);
    step(1, 1, 0, 0);
    chk("after vs col_x",  32'(col_x),        32'd1);
    chk("after vs slice0", 32'(col_out[1:0]), 32'd1);
    step(0, 0, 1, 0);
    chk("after vs width",  32'(width),        32'd2);
    step(0, 0, 0, 1);
    chk("vsync width hold", 32'(width),       32'd2);
    step(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised multi-line video buffer for the median-filter datapath. Sits between the HDMI receiver (pixel, data-valid, hsync, vsync) and the window/median core.
- Stores the last LINES video lines in circular BRAM banks and measures the active line width from hsync.
- For every incoming pixel it emits a vertical column of LINES+1 pixels at the same x position: the current pixel plus the pixels above it.

Parameters:
- DATA_W, 8, pixel width in bits
- ADDR_W, 11, line-address width; maximum line length is 2**ADDR_W pixels
- LINES, 2, number of stored previous lines (column height = LINES+1); legal range 1..8

Ports:
- clk  in  1  pixel clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- vsync  in  1  frame start strobe, one-cycle pulse
- hsync  in  1  line end strobe, one-cycle pulse
- din  in  DATA_W  incoming pixel
- din_valid  in  1  din qualifier
- col_out  out  (LINES+1)*DATA_W  column; [DATA_W-1:0] = current pixel, slice k = pixel k lines above
- col_x  out  ADDR_W  x position of col_out
- col_valid  out  1  col_out qualifier
- width  out  ADDR_W  pixel count of the last completed line
- rows_ready  out  1  at least LINES non-empty lines stored since the last vsync
- overflow  out  1  sticky per frame: a pixel arrived at address 2**ADDR_W-1 after it was already written

Behaviour:
- Reset (asynchronous, active-high): all outputs are 0; wr_addr=0, wr_bank=0, fill=0, px_in_line=0. Memory contents are not cleared.
- Write path: on din_valid, din is written to bank wr_bank at wr_addr, then wr_addr increments. wr_addr saturates at 2**ADDR_W-1. Pixels arriving after the last address has been written are dropped and set overflow.
- Read path: on din_valid, all LINES banks are read at wr_addr using synchronous read-first ports.
  - Bank wr_bank returns the line LINES lines above, before that entry is overwritten.
  - Latency is exactly 1 cycle: col_valid, col_x and col_out correspond to the din_valid of the previous cycle. din is registered to align with the BRAM read data.
- Column ordering:
  - Slice 0 = registered din.
  - Slice k (k=1..LINES) = bank (wr_bank - k) mod LINES, where slice LINES is the read-first data of wr_bank.
  - Bank selection uses the wr_bank value latched at read time.
- col_valid = registered din_valid AND rows_ready. While rows_ready=0, col_out still updates but col_valid stays 0.
- On hsync (and not vsync):
  - If px_in_line>0: width <= pixel count of the finished line, including a din_valid in the same cycle. wr_bank <= (wr_bank+1) mod LINES. fill <= min(fill+1, LINES). wr_addr <= 0. px_in_line <= 0.
  - If px_in_line==0 and there is no simultaneous din_valid: hsync is ignored (no width update, no bank rotation).
- Same-cycle din_valid and hsync: the pixel is written/read as the last pixel of the ending line. The address reset takes effect next cycle.
- On vsync: wr_addr=0, wr_bank=0, fill=0, px_in_line=0, overflow=0, rows_ready=0. width holds. A pipelined col_valid in flight is suppressed.
  - vsync wins over simultaneous hsync.
  - A simultaneous din_valid is written at address 0 of bank 0 and counts as the first pixel of the new frame.
- rows_ready = (fill==LINES), registered.
- Lines shorter than the previous line: the stale tail is never read, because reads only occur at written addresses.
- Reset mid-line: everything returns to reset values asynchronously. The next frame requires vsync or hsync sequencing as normal.

Decomposition:
- Shared package (median_pkg): pixel width constant, column-slice index helper, bank-index modulo function.
- Sub-module: existing dual-port bram (DATA_W, ADDR_W), instantiated LINES times via generate. Port A writes, port B is a read-first synchronous read at the same address.
- Address/line control (wr_addr, px_in_line, wr_bank, fill, width, overflow) lives inline in this module.

Test Plan:
- DATA_W=2, ADDR_W=3, LINES=2, reset released at 22 ns:
  - Line A = 2,3,0,3,0 then hsync -> width=5, rows_ready=0, col_valid never 1.
- Second line B = 1,0,3,0,3 then hsync -> fill=2, rows_ready=1 one cycle later, width=5.
- Third line C = 3,3,3,3,3 -> col_valid high 1 cycle after each din_valid; col_x=0..4; col_out at x=0 = {A0=2, B0=1, C0=3}, i.e. 6'b10_01_11.
- hsync with din_valid in the same cycle on the 4th pixel -> width=4, next pixel lands at address 0 of the next bank; back-to-back hsync with no pixels -> width unchanged, no bank rotation.
- 9 pixels on one line with ADDR_W=3 -> 8 written, overflow=1, col_x stays 7; vsync clears overflow, fill, rows_ready and col_valid.
- Assert rst mid-line asynchronously (between clk edges) -> all outputs 0 immediately; vsync+hsync in the same cycle -> vsync behaviour only.
